allpass_lattice_seq: RTL and testbench

//  Time-multiplexed N-stage lattice allpass filter. It drives the lattice

---
 rtl/allpass_lattice_seq_if.sv | 28 ++
 rtl/allpass_lattice_seq.sv | 146 ++++++++++++++
 tb/tb_allpass_lattice_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/allpass_lattice_seq_if.sv
// Stream and coefficient-port bundle for the time-multiplexed lattice allpass.
// The master side (the source of samples) drives the requests and the slave side (the filter) answers.
interface allpass_lattice_seq_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic                    clear;
  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [WIDTH-1:0] coef_data;
  logic                    coef_ready;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;

  modport master (
    output clear, coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
    input  coef_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  clear, coef_we, coef_addr, coef_data, in_valid, in_data, out_ready,
    output coef_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/allpass_lattice_seq.sv
// Time-multiplexed N-stage lattice allpass filter built around one shared multiplier.
// Each sample walks the stages downward (forward path) and then upward (backward path and state update).
module allpass_lattice_seq #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int AW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  allpass_lattice_seq_if.slave bus_io
);
  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [KW-1:0] KLAST = KW'(STAGES - 1);

  typedef enum logic [1:0] {IDLE, DOWN, UP, OUT} state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [WIDTH-1:0] f_q, f_d, g_q, g_d, y_q, y_d;
  logic signed [WIDTH-1:0] s_q [STAGES];
  logic signed [WIDTH-1:0] c_q [STAGES];
  logic                    pend_q;
  logic [KW-1:0]           pendAddr_q;
  logic signed [WIDTH-1:0] pendData_q;

  logic                    accept, coefOk, leaveBusy;
  logic signed [WIDTH-1:0] mulA, mulB, mulHi;
  logic signed [PW-1:0]    prod;

  // Both passes share the multiplier. The coefficient is always c[k]; the other operand is s[k] going down and g going up.
  assign mulA  = c_q[k_q];
  assign mulB  = (state_q == UP) ? g_q : s_q[k_q];
  assign prod  = PW'(mulA) * PW'(mulB);
  assign mulHi = prod[PW-1:WIDTH];

  assign accept    = (state_q == IDLE) && bus_io.in_valid && !bus_io.clear;
  assign coefOk    = (state_q == IDLE) && bus_io.coef_we && (int'(bus_io.coef_addr) < STAGES);
  assign leaveBusy = (state_q != IDLE) && (state_d == IDLE);
  assign bus_io.out_data = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      f_q     <= '0;
      g_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      f_q     <= f_d;
      g_q     <= g_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus_io.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = DOWN;
        DOWN:    if (k_q == '0) state_d = UP;
        UP:      if (k_q == KLAST) state_d = OUT;
        OUT:     if (bus_io.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus_io.in_ready   = 1'b0;
    bus_io.coef_ready = 1'b0;
    bus_io.out_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_io.in_ready   = rst_n;
        bus_io.coef_ready = 1'b1;
      end
      OUT:     bus_io.out_valid = 1'b1;
      default: ;
    endcase
  end

  // The last DOWN step hands the freshly updated f straight to g, so that step costs no extra cycle.
  always_comb begin
    k_d = k_q;
    f_d = f_q;
    g_d = g_q;
    y_d = y_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f_d = bus_io.in_data;
          k_d = KLAST;
        end
      end
      DOWN: begin
        f_d = f_q - mulHi;
        if (k_q == '0) g_d = f_d;
        else           k_d = k_q - KW'(1);
      end
      UP: begin
        g_d = s_q[k_q] + mulHi;
        if (k_q == KLAST) y_d = g_d;
        else              k_d = k_q + KW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) s_q[i] <= '0;
    end else if (bus_io.clear) begin
      for (int i = 0; i < STAGES; i++) s_q[i] <= '0;
    end else if (state_q == UP) begin
      s_q[k_q] <= g_q;
    end
  end

  // A write that arrives in the same cycle a sample is accepted is held back until the sample leaves.
  // This way the sample in flight still uses the old coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) c_q[i] <= '0;
      pend_q     <= 1'b0;
      pendAddr_q <= '0;
      pendData_q <= '0;
    end else begin
      if (coefOk && accept) begin
        pend_q     <= 1'b1;
        pendAddr_q <= bus_io.coef_addr[KW-1:0];
        pendData_q <= bus_io.coef_data;
      end else if (coefOk) begin
        c_q[bus_io.coef_addr[KW-1:0]] <= bus_io.coef_data;
      end
      if (pend_q && leaveBusy) begin
        c_q[pendAddr_q] <= pendData_q;
        pend_q          <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_allpass_lattice_seq.sv
// Bench for allpass_lattice_seq. A 4-stage and a 1-stage instance are each checked against a plain arithmetic lattice model.
// The model is a loop over stages: the forward pass runs downward, then the backward pass runs upward.
module tb_allpass_lattice_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr [2];
  logic        cWe [2];
  logic [3:0]  cAddr [2];
  logic [15:0] cData [2];
  logic        inV [2];
  logic [15:0] inD [2];
  logic        outR [2];
  logic        inRdy [2];
  logic        outV [2];
  logic [15:0] outD [2];

  allpass_lattice_seq_if #(.WIDTH(16), .AW(4)) bus0 ();
  allpass_lattice_seq_if #(.WIDTH(16), .AW(4)) bus1 ();

  assign bus0.clear = clr[0];   assign bus1.clear = clr[1];
  assign bus0.coef_we = cWe[0]; assign bus1.coef_we = cWe[1];
  assign bus0.coef_addr = cAddr[0]; assign bus1.coef_addr = cAddr[1];
  assign bus0.coef_data = cData[0]; assign bus1.coef_data = cData[1];
  assign bus0.in_valid = inV[0];  assign bus1.in_valid = inV[1];
  assign bus0.in_data = inD[0];   assign bus1.in_data = inD[1];
  assign bus0.out_ready = outR[0]; assign bus1.out_ready = outR[1];
  assign inRdy[0] = bus0.in_ready;  assign inRdy[1] = bus1.in_ready;
  assign outV[0] = bus0.out_valid;  assign outV[1] = bus1.out_valid;
  assign outD[0] = bus0.out_data;   assign outD[1] = bus1.out_data;

  allpass_lattice_seq #(.WIDTH(16), .STAGES(4), .AW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus_io(bus0.slave));
  allpass_lattice_seq #(.WIDTH(16), .STAGES(1), .AW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus_io(bus1.slave));

  int total = 0;
  int bad = 0;
  int S [2] = '{4, 1};
  int mS [2][16];
  int mC [2][16];
  logic [15:0] expQ0 [$];
  logic [15:0] expQ1 [$];

  function automatic int wrap(longint v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int mulHi(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return wrap(p >>> 16);
  endfunction

  function automatic logic [15:0] modelStep(int sel, logic [15:0] x);
    int f, g, ng;
    f = wrap(longint'($signed(x)));
    for (int k = S[sel] - 1; k >= 0; k--) f = wrap(longint'(f) - mulHi(mC[sel][k], mS[sel][k]));
    g = f;
    for (int k = 0; k < S[sel]; k++) begin
      ng = wrap(longint'(mS[sel][k]) + mulHi(mC[sel][k], g));
      mS[sel][k] = g;
      g = ng;
    end
    return 16'(g);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 16; k++) begin
        mS[s][k] = 0;
        mC[s][k] = 0;
      end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int sel, logic [15:0] x, bit track);
    int n = 0;
    while (!inRdy[sel] && n < 100) begin
      tick();
      n++;
    end
    check("in_ready-before-accept", 32'(inRdy[sel]), 1);
    inD[sel] = x;
    inV[sel] = 1'b1;
    tick();
    inV[sel] = 1'b0;
    if (track) begin
      if (sel == 0) expQ0.push_back(modelStep(0, x));
      else          expQ1.push_back(modelStep(1, x));
    end
  endtask

  task automatic waitValid(int sel, string tag);
    int n = 0;
    while (!outV[sel] && n < 100) begin
      tick();
      n++;
    end
    check({tag, "-valid"}, 32'(outV[sel]), 1);
  endtask

  task automatic checkOutput(int sel, string tag);
    logic [15:0] e;
    waitValid(sel, tag);
    e = 16'h0;
    if (sel == 0 && expQ0.size() > 0) e = expQ0.pop_front();
    if (sel == 1 && expQ1.size() > 0) e = expQ1.pop_front();
    check(tag, 32'(outD[sel]), 32'(e));
    outR[sel] = 1'b1;
    tick();
    outR[sel] = 1'b0;
    check({tag, "-drop"}, 32'(outV[sel]), 0);
  endtask

  task automatic writeCoef(int sel, logic [3:0] addr, logic [15:0] data, bit land);
    cWe[sel] = 1'b1;
    cAddr[sel] = addr;
    cData[sel] = data;
    tick();
    cWe[sel] = 1'b0;
    if (land) mC[sel][addr] = int'($signed(data));
  endtask

  task automatic quietCheck(int sel, int cycles, string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (outV[sel]) seen++;
      tick();
    end
    check(tag, 32'(seen), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] x2;
    int n;
    modelReset();
    for (int s = 0; s < 2; s++) begin
      clr[s] = 0; cWe[s] = 0; cAddr[s] = 0; cData[s] = 0;
      inV[s] = 0; inD[s] = 0; outR[s] = 0;
    end

    repeat (3) tick();
    check("rst-out_valid", 32'(outV[0]), 0);
    check("rst-out_data", 32'(outD[0]), 0);
    check("rst-in_ready0", 32'(inRdy[0]), 0);
    check("rst-in_ready1", 32'(inRdy[1]), 0);
    rst_n = 1'b1;
    #1;
    check("post-rst-in_ready", 32'(inRdy[0]), 1);

    // With all coefficients zero the 4-stage filter is a pure four-sample delay.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 16'(i), 1);
      checkOutput(0, "delay");
    end

    writeCoef(1, 0, 16'h4000, 1);
    applyStimulus(1, 16'h4000, 1);
    n = 0;
    while (!outV[1] && n < 20) begin
      tick();
      n++;
    end
    check("latency-1stage", 32'(n), 2);
    check("t2-y0-const", 32'(outD[1]), 32'h1000);
    checkOutput(1, "t2-y0");
    applyStimulus(1, 16'h0000, 1);
    waitValid(1, "t2-y1pre");
    check("t2-y1-const", 32'(outD[1]), 32'h3C00);
    checkOutput(1, "t2-y1");

    for (int k = 0; k < 4; k++) writeCoef(0, 4'(k), 16'($urandom), 1);
    applyStimulus(0, 16'($urandom), 1);
    waitValid(0, "bp-first");
    x2 = 16'($urandom);
    inD[0] = x2;
    inV[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp-hold-data", 32'(outD[0]), 32'(expQ0[0]));
      check("bp-in_ready", 32'(inRdy[0]), 0);
      tick();
    end
    checkOutput(0, "bp-y0");
    check("bp-accept-ready", 32'(inRdy[0]), 1);
    tick();
    inV[0] = 1'b0;
    expQ0.push_back(modelStep(0, x2));
    checkOutput(0, "bp-y1");

    // Writes in DOWN, in UP, and to an out-of-range address must all be dropped.
    applyStimulus(0, 16'h7FFF, 1);
    writeCoef(0, 1, 16'($urandom), 0);
    repeat (3) tick();
    writeCoef(0, 2, 16'($urandom), 0);
    checkOutput(0, "drop-busy");
    writeCoef(0, 4, 16'($urandom), 0);
    applyStimulus(0, 16'h7FFF, 1);
    checkOutput(0, "drop-impulse");
    cWe[0] = 1'b1; cAddr[0] = 0; cData[0] = 16'h2345;
    inV[0] = 1'b1; inD[0] = 16'h1234;
    expQ0.push_back(modelStep(0, 16'h1234));
    mC[0][0] = 32'sh2345;
    tick();
    cWe[0] = 1'b0;
    inV[0] = 1'b0;
    checkOutput(0, "same-cycle-old");
    applyStimulus(0, 16'h4321, 1);
    checkOutput(0, "same-cycle-new");

    writeCoef(1, 0, 16'h7FFF, 1);
    applyStimulus(1, 16'h7FFF, 1);
    checkOutput(1, "wrap0");
    applyStimulus(1, 16'h7FFF, 1);
    checkOutput(1, "wrap1");
    applyStimulus(1, 16'h8000, 1);
    checkOutput(1, "wrap2");

    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    for (int k = 0; k < 16; k++) mS[0][k] = 0;
    clr[0] = 1'b1;
    inV[0] = 1'b1;
    inD[0] = 16'h5555;
    tick();
    clr[0] = 1'b0;
    inV[0] = 1'b0;
    quietCheck(0, 12, "clear-wins");

    applyStimulus(0, 16'h3333, 0);
    repeat (5) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    for (int k = 0; k < 16; k++) mS[0][k] = 0;
    quietCheck(0, 12, "clear-midup-quiet");
    check("clear-midup-ready", 32'(inRdy[0]), 1);
    applyStimulus(0, 16'h0100, 1);
    checkOutput(0, "after-clear");

    applyStimulus(0, 16'h3333, 0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst-out_valid", 32'(outV[0]), 0);
    check("midrst-out_data", 32'(outD[0]), 0);
    check("midrst-in_ready", 32'(inRdy[0]), 0);
    tick();
    rst_n = 1'b1;
    #1;
    modelReset();
    quietCheck(0, 12, "midrst-quiet");
    applyStimulus(0, 16'h7777, 1);
    checkOutput(0, "after-rst");

    for (int k = 0; k < 4; k++) writeCoef(0, 4'(k), 16'($urandom), 1);
    writeCoef(1, 0, 16'($urandom), 1);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) writeCoef(0, 4'($urandom_range(0, 3)), 16'($urandom), 1);
      applyStimulus(0, 16'($urandom), 1);
      repeat ($urandom_range(0, 3)) tick();
      checkOutput(0, "rand4");
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 16'($urandom), 1);
      checkOutput(1, "rand1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
